// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one request at a time, held stable
// until the data cache responds, with stall, flush and misalignment.
module lsu_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic                flush,
    output logic                stall,
    output logic [XLEN-1:0]     dcache_address,
    output logic                dcache_read,
    output logic                dcache_write,
    output logic [XLEN-1:0]     dcache_wdata,
    output logic [XLEN/8-1:0]   dcache_mbe,
    input  logic                dcache_resp,
    input  logic [XLEN-1:0]     dcache_rdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_data,
    output logic                rsp_err
);

    localparam int OFFW = $clog2(XLEN/8);
    localparam int NB   = XLEN/8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rsp_data_q;
    logic [2:0]      f3_q;
    logic            store_q;
    logic            err_q;
    logic            kill_q;
    logic            rsp_valid_q;

    logic            busy;
    logic [OFFW-1:0] off;
    logic [OFFW+2:0] shamt;
    logic [15:0]     mbe_full;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] low_mask;
    logic [6:0]      size_bits;
    logic            sbit;
    logic [XLEN-1:0] ext;

    // Illegal encodings and misaligned addresses never reach the cache.
    function automatic logic bad_access(
        input logic       st,
        input logic [2:0] f3,
        input logic [2:0] a
    );
        logic ill;
        logic mis;
        ill = (f3 == 3'd7) || (st && f3[2])
           || ((XLEN == 32) && (f3[1:0] == 2'd3));
        unique case (f3[1:0])
            2'd0:    mis = 1'b0;
            2'd1:    mis = a[0];
            2'd2:    mis = |a[1:0];
            default: mis = |a;
        endcase
        return ill || mis;
    endfunction

    assign busy  = (state == BUSY);
    assign off   = addr_q[OFFW-1:0];
    assign shamt = {off, 3'b000};

    assign stall = ((state == IDLE) && req_valid && !flush) || busy;

    assign dcache_read    = busy && !store_q;
    assign dcache_write   = busy && store_q;
    assign dcache_address = busy ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}}
                                 : '0;
    assign dcache_wdata   = busy ? (wdata_q << shamt) : '0;

    assign mbe_full   = ((16'd1 << (5'd1 << f3_q[1:0])) - 16'd1) << off;
    assign dcache_mbe = busy ? mbe_full[NB-1:0] : '0;

    assign raw       = dcache_rdata >> shamt;
    assign size_bits = 7'd8 << f3_q[1:0];
    assign low_mask  = (XLEN'(1) << size_bits) - XLEN'(1);

    // Sign bit of the accessed field; double passes through.
    always_comb begin
        sbit = 1'b0;
        unique case (f3_q[1:0])
            2'd0:    sbit = raw[7];
            2'd1:    sbit = raw[15];
            2'd2:    sbit = raw[31];
            default: sbit = raw[XLEN-1];
        endcase
    end

    assign ext = (raw & low_mask)
               | ((sbit && !f3_q[2]) ? ~low_mask : '0);

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = err_q && !kill_q;

    // Request FSM: accept, wait for the cache, present one result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            store_q     <= 1'b0;
            err_q       <= 1'b0;
            kill_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        f3_q    <= req_funct3;
                        store_q <= req_store;
                        if (bad_access(req_store, req_funct3,
                                       req_addr[2:0])) begin
                            state       <= DONE;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (dcache_resp) begin
                        state       <= DONE;
                        rsp_valid_q <= !(kill_q || flush);
                        rsp_data_q  <= (store_q || kill_q || flush)
                                     ? '0 : ext;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    err_q       <= 1'b0;
                    kill_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage at XLEN 32 and 64.
// Each operation is run through one sequencing task, then checked.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v32 = 1'b0;
    logic        v64 = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata = '0;
    logic        flush = 1'b0;
    logic        resp = 1'b0;
    logic        w64 = 1'b0;

    logic        s32, rd32, wr32, vl32, er32;
    logic [31:0] ad32, wd32, dt32;
    logic [3:0]  mb32;
    logic        s64, rd64, wr64, vl64, er64;
    logic [63:0] ad64, wd64, dt64;
    logic [7:0]  mb64;

    logic        o_stall, o_rd, o_wr, o_valid, o_err;
    logic [63:0] o_addr, o_wdata, o_data;
    logic [7:0]  o_mbe;

    int tests = 0;
    int fails = 0;

    int          n_stall, n_rd, n_wr, n_valid, n_err;
    logic [63:0] got_data, got_addr, got_wdata;
    logic [7:0]  got_mbe;
    bit          hold_ok, timeout, post_bad;
    logic        rd_after_rst;

    always #5 clk = ~clk;

    lsu_mem_stage #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst),
        .req_valid(v32), .req_store(req_store),
        .req_funct3(f3), .req_addr(addr[31:0]),
        .req_wdata(wdata[31:0]), .flush(flush),
        .stall(s32), .dcache_address(ad32),
        .dcache_read(rd32), .dcache_write(wr32),
        .dcache_wdata(wd32), .dcache_mbe(mb32),
        .dcache_resp(resp), .dcache_rdata(rdata[31:0]),
        .rsp_valid(vl32), .rsp_data(dt32), .rsp_err(er32)
    );

    lsu_mem_stage #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst),
        .req_valid(v64), .req_store(req_store),
        .req_funct3(f3), .req_addr(addr),
        .req_wdata(wdata), .flush(flush),
        .stall(s64), .dcache_address(ad64),
        .dcache_read(rd64), .dcache_write(wr64),
        .dcache_wdata(wd64), .dcache_mbe(mb64),
        .dcache_resp(resp), .dcache_rdata(rdata),
        .rsp_valid(vl64), .rsp_data(dt64), .rsp_err(er64)
    );

    always_comb begin
        o_stall = w64 ? s64 : s32;
        o_rd    = w64 ? rd64 : rd32;
        o_wr    = w64 ? wr64 : wr32;
        o_valid = w64 ? vl64 : vl32;
        o_err   = w64 ? er64 : er32;
        o_addr  = w64 ? ad64 : {32'd0, ad32};
        o_wdata = w64 ? wd64 : {32'd0, wd32};
        o_data  = w64 ? dt64 : {32'd0, dt32};
        o_mbe   = w64 ? mb64 : {4'd0, mb32};
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input bit sel, input bit st,
                      input logic [2:0] fn,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] rd,
                      input int resp_at, input int flush_at,
                      input int rst_at);
        int busy_n;
        n_stall = 0; n_rd = 0; n_wr = 0; n_valid = 0; n_err = 0;
        got_data = '0; got_addr = '0; got_wdata = '0; got_mbe = '0;
        hold_ok = 1'b1; timeout = 1'b1; post_bad = 1'b0;
        rd_after_rst = 1'b0;
        busy_n = 0;
        w64 = sel; req_store = st; f3 = fn;
        addr = a; wdata = wd; rdata = rd;
        resp = 1'b0; flush = 1'b0;
        if (sel) v64 = 1'b1;
        else v32 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (o_stall) n_stall++;
            if (o_valid) begin
                n_valid++;
                got_data = o_data;
            end
            if (o_err) n_err++;
            if (o_rd) n_rd++;
            if (o_wr) n_wr++;
            if (o_rd || o_wr) begin
                busy_n++;
                if (busy_n == 1) begin
                    got_addr = o_addr;
                    got_wdata = o_wdata;
                    got_mbe = o_mbe;
                end else if (o_addr != got_addr ||
                             o_wdata != got_wdata ||
                             o_mbe != got_mbe) begin
                    hold_ok = 1'b0;
                end
            end
            if (c > 0 && !o_stall) begin
                v32 = 1'b0; v64 = 1'b0;
                @(posedge clk); #2;
                if (o_valid || o_err || o_rd || o_wr)
                    post_bad = 1'b1;
                timeout = 1'b0;
                break;
            end
            if (rst_at > 0 && busy_n == rst_at) begin
                v32 = 1'b0; v64 = 1'b0;
                rst = 1'b0;
                #1;
                rd_after_rst = o_rd || o_wr;
                @(posedge clk); #1;
                rst = 1'b1;
                @(posedge clk); #1;
                timeout = 1'b0;
                break;
            end
            resp  = (o_rd || o_wr) && busy_n == resp_at;
            flush = (o_rd || o_wr) && busy_n == flush_at;
            @(posedge clk); #1;
            resp = 1'b0; flush = 1'b0;
        end
        v32 = 1'b0; v64 = 1'b0;
    endtask

    initial begin
        // reset state, both widths
        repeat (2) @(posedge clk);
        #1;
        w64 = 1'b0; #1;
        chk("rst32_rd", o_rd, 0);
        chk("rst32_addr", o_addr, 0);
        chk("rst32_mbe", o_mbe, 0);
        chk("rst32_valid", o_valid, 0);
        chk("rst32_err", o_err, 0);
        chk("rst32_stall", o_stall, 0);
        v32 = 1'b1; #1;
        chk("rst32_stall_req", o_stall, 1);
        v32 = 1'b0;
        w64 = 1'b1; #1;
        chk("rst64_wr", o_wr, 0);
        chk("rst64_wdata", o_wdata, 0);
        chk("rst64_data", o_data, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // LB 0x1003, response in first BUSY cycle
        op(0, 0, 3'd0, 64'h1003, 64'h0, 64'h80FF_1234, 1, 0, 0);
        chk("lb_done", timeout, 0);
        chk("lb_addr", got_addr, 64'h1000);
        chk("lb_data", got_data, 64'hFFFF_FF80);
        chk("lb_stall", n_stall, 2);
        chk("lb_rd", n_rd, 1);
        chk("lb_wr", n_wr, 0);
        chk("lb_valid", n_valid, 1);
        chk("lb_post", post_bad, 0);

        // SH 0x2002, response in fifth BUSY cycle
        op(0, 1, 3'd1, 64'h2002, 64'h0000_ABCD, 64'h0, 5, 0, 0);
        chk("sh_done", timeout, 0);
        chk("sh_wdata", got_wdata, 64'hABCD_0000);
        chk("sh_mbe", got_mbe, 8'h0C);
        chk("sh_wr", n_wr, 5);
        chk("sh_rd", n_rd, 0);
        chk("sh_hold", hold_ok, 1);
        chk("sh_stall", n_stall, 6);
        chk("sh_valid", n_valid, 1);
        chk("sh_data", got_data, 0);

        // LW 0x3001, misaligned
        op(0, 0, 3'd2, 64'h3001, 64'h0, 64'h0, 1, 0, 0);
        chk("lwmis_done", timeout, 0);
        chk("lwmis_rd", n_rd, 0);
        chk("lwmis_stall", n_stall, 1);
        chk("lwmis_err", n_err, 1);
        chk("lwmis_valid", n_valid, 1);

        // LHU 0x40, flush in BUSY 2, response in BUSY 3
        op(0, 0, 3'd5, 64'h40, 64'h0, 64'h1234_5678, 3, 2, 0);
        chk("flush_done", timeout, 0);
        chk("flush_rd", n_rd, 3);
        chk("flush_hold", hold_ok, 1);
        chk("flush_valid", n_valid, 0);
        chk("flush_err", n_err, 0);

        // SB with funct3[2] set is illegal
        op(0, 1, 3'd4, 64'h10, 64'h55, 64'h0, 1, 0, 0);
        chk("sbu_wr", n_wr, 0);
        chk("sbu_err", n_err, 1);

        // XLEN 64: LWU 0x4
        op(1, 0, 3'd6, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 2, 0, 0);
        chk("lwu_done", timeout, 0);
        chk("lwu_addr", got_addr, 64'h0);
        chk("lwu_data", got_data, 64'h0000_0000_8765_4321);
        chk("lwu_stall", n_stall, 3);

        // XLEN 64: LW sign-extends
        op(1, 0, 3'd2, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 1, 0, 0);
        chk("lw64_data", got_data, 64'hFFFF_FFFF_8765_4321);

        // XLEN 64: SD 0x8
        op(1, 1, 3'd3, 64'h8, 64'h1122_3344_5566_7788, 64'h0, 1, 0, 0);
        chk("sd_done", timeout, 0);
        chk("sd_mbe", got_mbe, 8'hFF);
        chk("sd_addr", got_addr, 64'h8);
        chk("sd_wdata", got_wdata, 64'h1122_3344_5566_7788);
        chk("sd_wr", n_wr, 1);

        // XLEN 64: LD 0xC misaligned
        op(1, 0, 3'd3, 64'hC, 64'h0, 64'h0, 1, 0, 0);
        chk("ldmis_err", n_err, 1);
        chk("ldmis_rd", n_rd, 0);

        // XLEN 32: LD is illegal
        op(0, 0, 3'd3, 64'h0, 64'h0, 64'h0, 1, 0, 0);
        chk("ld32_err", n_err, 1);

        // reset during BUSY 2 of an LW
        op(0, 0, 3'd2, 64'h100, 64'h0, 64'h0, 99, 0, 2);
        chk("rstmid_done", timeout, 0);
        chk("rstmid_rd", rd_after_rst, 0);
        chk("rstmid_valid", o_valid, 0);

        // LB 0x0 after reset
        op(0, 0, 3'd0, 64'h0, 64'h0, 64'h0000_00F5, 1, 0, 0);
        chk("lb0_done", timeout, 0);
        chk("lb0_data", got_data, 64'hFFFF_FFF5);
        chk("lb0_stall", n_stall, 2);
        chk("lb0_valid", n_valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Parametrised load/store unit for the MEM stage of the pipelined RV32I/RV64I core. It sits between the EX/MEM pipeline registers and the data cache. It latches one memory request at a time and holds the cache handshake stable until `dcache_resp`. It raises `stall` to freeze the upstream pipeline while the request is outstanding, then returns aligned, sign- or zero-extended load data for the MEM/WB registers. It generalises the fixed 32-bit store-mask and load-extract logic: the data width is configurable, it adds a cache-response handshake with stall and flush handling, and it detects misaligned accesses.

## Interface
- `XLEN`, default 32 — datapath width; legal values are 32 and 64.
- `OFFW`, derived as log2(XLEN/8) — number of byte-offset bits. This is a localparam, not an override.
- `clk`  in  1 — clock.
- `rst`  in  1 — reset, asynchronous, active-low.
- `req_valid`  in  1 — EX/MEM holds a load or store.
- `req_store`  in  1 — 1 = store, 0 = load.
- `req_funct3`  in  3 — RISC-V funct3 of the load or store.
- `req_addr`  in  XLEN — effective address (ALU result).
- `req_wdata`  in  XLEN — rs2 value, unshifted.
- `flush`  in  1 — kill the current request's result.
- `stall`  out  1 — freeze the PC and the IF/ID, ID/EX and EX/MEM registers.
- `dcache_address`  out  XLEN — request address with the low `OFFW` bits cleared.
- `dcache_read`  out  1 — cache read strobe.
- `dcache_write`  out  1 — cache write strobe.
- `dcache_wdata`  out  XLEN — store data shifted into its byte lanes.
- `dcache_mbe`  out  XLEN/8 — byte-enable mask.
- `dcache_resp`  in  1 — cache completes the request this cycle.
- `dcache_rdata`  in  XLEN — cache read data, valid while `dcache_resp` is 1.
- `rsp_valid`  out  1 — load or store completed; this is a one-cycle pulse.
- `rsp_data`  out  XLEN — extended load data; 0 for stores.
- `rsp_err`  out  1 — the access was misaligned or used an illegal funct3.

## Operation
- The state machine has three states: IDLE, BUSY and DONE. Reset enters IDLE.
- Access size and extension are decoded from funct3:
  - funct3[1:0] gives the size: 0 = byte, 1 = half, 2 = word, 3 = double.
  - funct3[2] = 1 selects zero-extension.
  - The access is illegal if the size is double with XLEN = 32, if funct3 is 7, or if the instruction is a store with funct3[2] = 1.
  - The access is misaligned if `req_addr[size-1:0]` is non-zero for sizes of half or larger.
- IDLE:
  - If `req_valid` is 1 and `flush` is 0, the unit latches the address, store flag, funct3 and data.
  - If the access is illegal or misaligned, the next state is DONE with `err_q` set, and no cache strobe is issued.
  - Otherwise the next state is BUSY.
  - If `flush` is 1, the request is ignored.
- BUSY:
  - The unit drives the cache outputs from the latched values, holding them constant every cycle.
  - When `dcache_resp` arrives, the unit captures the load result and moves to DONE.
  - `flush` during BUSY does not abort the cache access. It sets the sticky `kill_q` flag instead.
- DONE (exactly one cycle):
  - `rsp_valid` = 1 unless `kill_q` is set.
  - `rsp_err` = `err_q`, also suppressed by `kill_q`.
  - `req_valid` is ignored, because the same instruction is still present in EX/MEM.
  - The next state is IDLE, and `kill_q` and `err_q` clear.
- `stall` = (IDLE & `req_valid` & !`flush`) | BUSY. It is combinational and is 0 in DONE.
- Store lanes:
  - `dcache_wdata` = `req_wdata` << (8 × offset).
  - `dcache_mbe` = ((1 << 2^size) − 1) << offset.
  - Both widths truncate to XLEN and XLEN/8.
- Load extraction:
  - The raw value is `dcache_rdata` >> (8 × offset).
  - It is sign-extended from bit 8·2^size − 1, or zero-extended when funct3[2] = 1.
  - A double-size load passes the value through unchanged.
- Outside BUSY, all cache outputs (strobes, address, data, mask) are 0.
- Reset values: `dcache_read`, `dcache_write`, `dcache_address`, `dcache_wdata`, `dcache_mbe`, `rsp_valid`, `rsp_data` and `rsp_err` are all 0. `stall` follows the formula above with the state at IDLE.
- Reset asserted mid-operation forces IDLE at once. The strobes drop asynchronously and the outstanding cache response is abandoned.

## Timing
- Minimum occupancy is 3 cycles: the IDLE accept cycle, at least one BUSY cycle, and the DONE cycle.
- `dcache_resp` may arrive in the first BUSY cycle.
- The cache strobes assert in the cycle after acceptance and deassert in the cycle after `dcache_resp`.
- Stall cycles for a legal access = 1 + N, where N is the number of BUSY cycles including the `dcache_resp` cycle.
- A misaligned or illegal access stalls for exactly 1 cycle and issues no cache strobe.
- `rsp_valid`, `rsp_data` and `rsp_err` are registered outputs. They are valid only during DONE.
- Back-to-back memory operations have no overlap. The next request is accepted in the IDLE cycle that follows DONE.

## Test plan
- LB, XLEN = 32, `req_addr` = 0x1003, `dcache_rdata` = 0x80FF_1234, response in the first BUSY cycle → `dcache_address` = 0x1000, `rsp_data` = 0xFFFF_FF80, `stall` high for 2 cycles.
- SH, `req_addr` = 0x2002, `req_wdata` = 0x0000_ABCD, response in the 5th BUSY cycle → `dcache_wdata` = 0xABCD_0000 and `dcache_mbe` = 4'b1100, held for 5 cycles; `stall` high for 6 cycles; `rsp_valid` pulses once with `rsp_data` = 0.
- LW at 0x3001 → `dcache_read` never asserts, `stall` high for 1 cycle, `rsp_err` = 1 in DONE.
- LHU at 0x40, with `flush` asserted in the 2nd BUSY cycle and the response in the 3rd → `dcache_read` is held until the response, `rsp_valid` = 0 and `rsp_err` = 0 throughout.
- XLEN = 64:
  - LWU at 0x4 with rdata 0x8765_4321_0000_0000 → `rsp_data` = 0x0000_0000_8765_4321.
  - SD at 0x8 → `dcache_mbe` = 8'hFF.
  - LD at 0xC → `rsp_err` = 1.
- `rst` driven low during the 2nd BUSY cycle of an LW → `dcache_read` = 0 immediately. After release, the unit is in IDLE and a new LB at 0x0 completes normally.
